// File: rtl/ex_operand_stage.sv
// ex_operand_stage: elastic two-entry operand register between decode and the
// execute compare/ALU logic. A main entry drives the outputs and a skid entry
// absorbs one cycle of downstream back-pressure, so o_in_ready is a pure
// register output. Writeback forwarding is applied on capture and every cycle
// to held entries. Flush drops everything held and incoming.
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    // decode side
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [REG_ADDR_W-1:0] i_in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_in_rs2_addr,
    input  logic [XLEN-1:0]       i_in_rs1_data,
    input  logic [XLEN-1:0]       i_in_rs2_data,
    input  logic [OP_W-1:0]       i_in_op,
    input  logic [XLEN-1:0]       i_in_pc,
    // writeback snoop port
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_data,
    // execute side
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [XLEN-1:0]       o_out_operand_a,
    output logic [XLEN-1:0]       o_out_operand_b,
    output logic [OP_W-1:0]       o_out_op,
    output logic [XLEN-1:0]       o_out_pc
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]       opnd_a;
        logic [XLEN-1:0]       opnd_b;
        logic [OP_W-1:0]       op;
        logic [XLEN-1:0]       pc;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;      // incoming item after capture forwarding
    entry_t main_snoop;    // held main entry after writeback snoop
    entry_t skid_snoop;    // held skid entry after writeback snoop

    logic wb_fwd_en;
    logic accept;
    logic consume;

    // Picks the writeback value when it targets this operand's source register.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic                  hit_en,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [REG_ADDR_W-1:0] rs_addr,
        input logic [XLEN-1:0]       wb_data,
        input logic [XLEN-1:0]       stored
    );
        return (hit_en && (wb_addr == rs_addr)) ? wb_data : stored;
    endfunction

    // x0 is hard-wired to zero, so a writeback to it never forwards.
    assign wb_fwd_en = i_wb_en && (i_wb_addr != '0);

    assign accept  = i_in_valid && o_in_ready;
    assign consume = main_q.valid && i_out_ready;

    // Build the incoming entry with forwarding from a same-cycle writeback.
    always_comb begin
        in_entry          = '0;
        in_entry.valid    = 1'b1;
        in_entry.rs1_addr = i_in_rs1_addr;
        in_entry.rs2_addr = i_in_rs2_addr;
        in_entry.opnd_a   = fwd_operand(wb_fwd_en, i_wb_addr, i_in_rs1_addr,
                                        i_wb_data, i_in_rs1_data);
        in_entry.opnd_b   = fwd_operand(wb_fwd_en, i_wb_addr, i_in_rs2_addr,
                                        i_wb_data, i_in_rs2_data);
        in_entry.op       = i_in_op;
        in_entry.pc       = i_in_pc;
    end

    // Refresh operands of held entries from the writeback port.
    always_comb begin
        main_snoop = main_q;
        skid_snoop = skid_q;
        if (main_q.valid) begin
            main_snoop.opnd_a = fwd_operand(wb_fwd_en, i_wb_addr, main_q.rs1_addr,
                                            i_wb_data, main_q.opnd_a);
            main_snoop.opnd_b = fwd_operand(wb_fwd_en, i_wb_addr, main_q.rs2_addr,
                                            i_wb_data, main_q.opnd_b);
        end
        if (skid_q.valid) begin
            skid_snoop.opnd_a = fwd_operand(wb_fwd_en, i_wb_addr, skid_q.rs1_addr,
                                            i_wb_data, skid_q.opnd_a);
            skid_snoop.opnd_b = fwd_operand(wb_fwd_en, i_wb_addr, skid_q.rs2_addr,
                                            i_wb_data, skid_q.opnd_b);
        end
    end

    // Next-state: consume/advance, then route an accepted item; flush wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        main_d = main_snoop;
        skid_d = skid_snoop;
        if (i_flush) begin
            // A concurrent consume has already been seen by execute; an
            // incoming item is simply not captured.
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else begin
            if (consume) begin
                if (skid_q.valid) begin
                    // Skid advances carrying any same-cycle forwarded value.
                    main_d       = skid_snoop;
                    skid_d.valid = 1'b0;
                end else begin
                    main_d.valid = 1'b0;
                end
            end
            if (accept) begin
                // accept implies the skid is empty (o_in_ready = !skid valid).
                if (!main_q.valid || (consume && !skid_q.valid)) begin
                    main_d = in_entry;
                end else begin
                    skid_d = in_entry;
                end
            end
        end
    end

    // Entry registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: data fields are cleared too; only valid matters functionally, zeros keep waveforms deterministic.
            main_q <= '0;
            skid_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Outputs come straight from registers; no combinational path from i_out_ready.
    assign o_in_ready      = !skid_q.valid;
    assign o_out_valid     = main_q.valid;
    assign o_out_operand_a = main_q.opnd_a;
    assign o_out_operand_b = main_q.opnd_b;
    assign o_out_op        = main_q.op;
    assign o_out_pc        = main_q.pc;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic,
// checked against an in-order queue model of the stage.
module tb_ex_operand_stage;

    localparam logic [3:0] OP_SLT = 4'h2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d;
    logic [3:0]  op;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_pc;
    logic [3:0]  out_op;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_rs1_addr(rs1a), .i_in_rs2_addr(rs2a),
        .i_in_rs1_data(rs1d), .i_in_rs2_data(rs2d),
        .i_in_op(op), .i_in_pc(pc),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_operand_a(out_a), .o_out_operand_b(out_b),
        .o_out_op(out_op), .o_out_pc(out_pc)
    );

    // ---------------- reference model: an in-order queue of at most two items
    typedef struct {
        logic [4:0]  ra1, ra2;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] pc;
    } item_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] pc;
    } obs_t;

    item_t mq[$];

    function automatic bit wb_hit(input logic [4:0] addr);
        return wb_en && (wb_addr != 5'd0) && (wb_addr == addr);
    endfunction

    // One clock edge of the model, using the inputs presented this cycle.
    task automatic model_edge();
        bit    room, acc, cons;
        item_t it;
        room = (mq.size() < 2);
        acc  = in_valid && room;
        cons = (mq.size() > 0) && out_ready;
        foreach (mq[i]) begin
            if (wb_hit(mq[i].ra1)) mq[i].a = wb_data;
            if (wb_hit(mq[i].ra2)) mq[i].b = wb_data;
        end
        if (cons) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (acc) begin
            it.ra1 = rs1a; it.ra2 = rs2a;
            it.a   = wb_hit(rs1a) ? wb_data : rs1d;
            it.b   = wb_hit(rs2a) ? wb_data : rs2d;
            it.op  = op; it.pc = pc;
            mq.push_back(it);
        end
    endtask

    function automatic obs_t model_obs();
        obs_t e = '0;
        e.ready = (mq.size() < 2);
        if (mq.size() > 0) begin
            e.valid = 1'b1;
            e.a = mq[0].a; e.b = mq[0].b; e.op = mq[0].op; e.pc = mq[0].pc;
        end
        return e;
    endfunction

    function automatic obs_t dut_obs();
        obs_t g;
        g.valid = out_valid; g.ready = in_ready;
        g.a = out_a; g.b = out_b; g.op = out_op; g.pc = out_pc;
        return g;
    endfunction

    // Data outputs only carry meaning while o_out_valid is expected high.
    function automatic bit obs_eq(input obs_t g, input obs_t e);
        if (!e.valid) return (g.valid === 1'b0) && (g.ready === e.ready);
        return g === e;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("v=%0b rdy=%0b a=%h b=%h op=%h pc=%h",
                         o.valid, o.ready, o.a, o.b, o.op, o.pc);
    endfunction

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_item(input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [3:0] o, input logic [31:0] p);
        in_valid = 1'b1;
        rs1a = a1; rs2a = a2; rs1d = d1; rs2d = d2; op = o; pc = p;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0;
        rs1a = '0; rs2a = '0; rs1d = '0; rs2d = '0; op = '0; pc = '0;
    endtask

    task automatic drain();
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        obs_t g, e;
        e = '0; e.ready = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        g = dut_obs(); n_cmp++;
        if (g !== e) begin
            n_err++; $display("FAIL reset_state: got %s want %s", fmt(g), fmt(e));
        end
        repeat (2) @(posedge clk);
        #1;
        g = dut_obs(); n_cmp++;
        if (g !== e) begin
            n_err++; $display("FAIL reset_held: got %s want %s", fmt(g), fmt(e));
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_first_item();
        out_ready = 1'b1;
        drive_item(5'd1, 5'd2, 32'hFFFF_FFFE, 32'h1, OP_SLT, 32'h100);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_a !== 32'hFFFF_FFFE || out_b !== 32'h1 || out_op !== OP_SLT) begin
            n_err++;
            $display("FAIL first_item: got v=%0b a=%h b=%h op=%h want v=1 a=fffffffe b=00000001 op=%h",
                     out_valid, out_a, out_b, out_op, OP_SLT);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL first_item_drained: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] seen[$];
        logic [31:0] want[3] = '{32'hA0, 32'hB0, 32'hC0};
        bit          c_taken = 0;
        out_ready = 1'b0;
        drive_item(5'd3, 5'd4, 32'h0A, 32'h0A, 4'h1, want[0]); tick();
        drive_item(5'd3, 5'd4, 32'h0B, 32'h0B, 4'h1, want[1]); tick();
        drive_item(5'd3, 5'd4, 32'h0C, 32'h0C, 4'h1, want[2]); tick();
        n_cmp++;
        if (out_pc !== want[0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_full: got v=%0b rdy=%0b pc=%h want v=1 rdy=0 pc=%h", out_valid, in_ready, out_pc, want[0]);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            obs_t g, e;
            g = dut_obs(); e = model_obs(); n_cmp++;
            if (!obs_eq(g, e)) begin
                n_err++; $display("FAIL bp_model: got %s want %s", fmt(g), fmt(e));
            end
            if (out_valid) seen.push_back(out_pc);
            if (in_valid && in_ready) c_taken = 1;
            tick();
            if (c_taken) in_valid = 1'b0;
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2]) begin
            n_err++; $display("FAIL bp_order: got %0d items %p want 3 items %p", seen.size(), seen, want);
        end
    endtask

    task automatic test_capture_forward();
        out_ready = 1'b1;
        drive_item(5'd5, 5'd6, 32'h10, 32'h20, 4'h3, 32'h200);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h99;
        tick();
        drive_item(5'd0, 5'd6, 32'h10, 32'h20, 4'h3, 32'h204);
        wb_addr = 5'd0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_a !== 32'h99 || out_b !== 32'h20) begin
            n_err++; $display("FAIL fwd_capture: got v=%0b a=%h b=%h want v=1 a=00000099 b=00000020", out_valid, out_a, out_b);
        end
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_a !== 32'h10 || out_pc !== 32'h204) begin
            n_err++; $display("FAIL fwd_x0: got v=%0b a=%h pc=%h want v=1 a=00000010 pc=00000204", out_valid, out_a, out_pc);
        end
        drain();
    endtask

    task automatic test_snoop();
        out_ready = 1'b0;
        drive_item(5'd1, 5'd7, 32'h1, 32'h3, 4'h4, 32'h300);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_b !== 32'h3) begin
            n_err++; $display("FAIL snoop_before: got b=%h want b=00000003", out_b);
        end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h8000_0000;
        tick();
        wb_en = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_b !== 32'h8000_0000 || out_pc !== 32'h300 || out_op !== 4'h4) begin
            n_err++;
            $display("FAIL snoop_held: got v=%0b b=%h pc=%h op=%h want v=1 b=80000000 pc=00000300 op=4",
                     out_valid, out_b, out_pc, out_op);
        end
        drain();
    endtask

    task automatic test_flush();
        int leaked = 0;
        out_ready = 1'b0;
        drive_item(5'd1, 5'd2, 32'h1, 32'h2, 4'h5, 32'h400); tick();
        drive_item(5'd1, 5'd2, 32'h1, 32'h2, 4'h5, 32'h404); tick();
        drive_item(5'd1, 5'd2, 32'h1, 32'h2, 4'h5, 32'h408);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_state: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) begin
            if (out_valid) leaked++;
            tick();
        end
        n_cmp++;
        if (leaked != 0) begin
            n_err++; $display("FAIL flush_leak: got %0d flushed items on output want 0", leaked);
        end
    endtask

    task automatic test_async_reset();
        obs_t g, e;
        out_ready = 1'b0;
        drive_item(5'd1, 5'd2, 32'h11, 32'h22, 4'h6, 32'h500); tick();
        drive_item(5'd1, 5'd2, 32'h33, 32'h44, 4'h6, 32'h504); tick();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        mq.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_a !== 32'h0 || out_pc !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b rdy=%0b a=%h pc=%h want v=0 rdy=1 a=0 pc=0",
                     out_valid, in_ready, out_a, out_pc);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive_item(5'd9, 5'd10, 32'h55, 32'h66, 4'h7, 32'h600);
        tick();
        in_valid = 1'b0;
        g = dut_obs(); e = model_obs(); n_cmp++;
        if (!obs_eq(g, e) || !out_valid) begin
            n_err++; $display("FAIL after_reset: got %s want %s", fmt(g), fmt(e));
        end
        drain();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            obs_t g, e;
            in_valid  = ($urandom_range(0, 9) < 7);
            rs1a      = 5'($urandom_range(0, 3));
            rs2a      = 5'($urandom_range(0, 3));
            rs1d      = $urandom; rs2d = $urandom;
            op        = 4'($urandom); pc = $urandom;
            out_ready = ($urandom_range(0, 9) < 5);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_addr   = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 24) == 0);
            g = dut_obs(); e = model_obs(); n_cmp++;
            if (!obs_eq(g, e)) begin
                n_err++; $display("FAIL random[%0d]: got %s want %s", cyc, fmt(g), fmt(e));
            end
            tick();
        end
        idle_inputs();
        drain();
    endtask

    initial begin
        test_reset();
        test_first_item();
        test_back_pressure();
        test_capture_forward();
        test_snoop();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
